// File: rtl/clint_trap_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clint_trap_ctrl_pkg
//
// Constants shared by the CLINT-side trap sequencer:
//   - machine-mode CSR addresses written or read by the sequencer
//   - mcause values for the machine timer interrupt and M-mode ECALL
//   - mstatus bit positions touched by trap entry / MRET
//   - sequencer state encoding
// ----------------------------------------------------------------------------
package clint_trap_ctrl_pkg;

    // CSR addresses
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    // mcause values (bit 63 set marks an interrupt)
    localparam logic [63:0] MCAUSE_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] MCAUSE_ECALL = 64'd11;

    // mstatus bit indices
    localparam int MSTATUS_MIE     = 3;
    localparam int MSTATUS_MPIE    = 7;
    localparam int MSTATUS_MPP_LO  = 11;
    localparam int MSTATUS_MPP_HI  = 12;

    // mtvec mode field value selecting vectored interrupts
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MSTATUS = 3'd3,
        ST_R_MSTATUS = 3'd4,
        ST_JUMP      = 3'd5
    } trap_state_e;

endpackage : clint_trap_ctrl_pkg

// File: rtl/clint_trap_ctrl.sv
// ----------------------------------------------------------------------------
// clint_trap_ctrl
//
// Machine-mode trap sequencer sitting on the CLINT write port of the CSR
// file. It is the only driver of clint_csr_wen/waddr/wdata.
//
// At instruction commit it accepts a machine timer interrupt, an ECALL or an
// MRET (priority in that order). A trap writes mepc, mcause and mstatus one
// CSR per cycle, then redirects fetch to the trap vector. An MRET rewrites
// mstatus and redirects fetch to mepc. The pipeline is stalled from the
// trigger cycle up to and including the redirect cycle.
//
// A CPU CSR write has priority in the CSR file; while cpu_csr_wen_i is high
// in a write state the sequencer holds its state and retries next cycle.
//
// Optional build macro:
//   CLINT_VECTORED_EN - when defined, interrupts with mtvec[1:0]==2'b01 jump
//                       to base + 4*cause[62:0]; exceptions still go to base.
//                       When undefined, direct mode only (mtvec[1:0] ignored).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   inst_valid_i        instruction commits this cycle
//   pc_i                PC of the committing instruction
//   ecall_i, mret_i     committing instruction is ECALL / MRET
//   cpu_csr_wen_i       CPU writes a CSR this cycle (wins the CSR file port)
//   csr_mtvec_i         current mtvec
//   csr_mepc_i          current mepc
//   csr_mstatus_i       current mstatus
//   global_int_en_i     mstatus.MIE
//   mtime_int_en_i      mie.MTIE
//   mtime_int_pend_i    mip.MTIP
//   clint_csr_wen_o     CSR write strobe
//   clint_csr_waddr_o   CSR write address
//   clint_csr_wdata_o   CSR write data (0 when no write)
//   stall_o             hold the pipeline
//   trap_jump_o         one-cycle fetch redirect strobe
//   trap_pc_o           redirect target (0 when no redirect)
// ----------------------------------------------------------------------------
module clint_trap_ctrl
    import clint_trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] CAUSE_MTI   = MCAUSE_MTI,
    parameter logic [XLEN-1:0] CAUSE_ECALL = MCAUSE_ECALL
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            cpu_csr_wen_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic            global_int_en_i,
    input  logic            mtime_int_en_i,
    input  logic            mtime_int_pend_i,
    output logic            clint_csr_wen_o,
    output logic [11:0]     clint_csr_waddr_o,
    output logic [XLEN-1:0] clint_csr_wdata_o,
    output logic            stall_o,
    output logic            trap_jump_o,
    output logic [XLEN-1:0] trap_pc_o
);

    // ------------------------------------------------------------------
    // mstatus updates
    // ------------------------------------------------------------------

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                 = s;
        r[MSTATUS_MPIE]                   = s[MSTATUS_MIE];
        r[MSTATUS_MIE]                    = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        return r;
    endfunction

    // MRET: MIE <- MPIE, MPIE <- 1, MPP stays at M (only M-mode exists).
    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                                 = s;
        r[MSTATUS_MIE]                    = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                   = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    trap_state_e     state_q,   state_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] cause_q,   cause_d;
    logic            is_mret_q, is_mret_d;

    logic            irq_take;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    assign irq_take  = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    assign trap_base = {csr_mtvec_i[XLEN-1:2], 2'b00};

`ifdef CLINT_VECTORED_EN
    // Interrupts jump into the vector table slot indexed by the cause code.
    always_comb begin
        trap_target = trap_base;
        if (csr_mtvec_i[1:0] == MTVEC_MODE_VECTORED && cause_q[XLEN-1]) begin
            trap_target = trap_base + {cause_q[XLEN-3:0], 2'b00};
        end
    end
`else
    // Direct mode only: the mode field of mtvec has no effect.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
    assign trap_target       = trap_base;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cause_q   <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            is_mret_q <= is_mret_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        cause_d           = cause_q;
        is_mret_d         = is_mret_q;
        clint_csr_wen_o   = 1'b0;
        clint_csr_waddr_o = 12'h000;
        clint_csr_wdata_o = '0;
        stall_o           = 1'b0;
        trap_jump_o       = 1'b0;
        trap_pc_o         = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Triggers only count with a committing instruction; the
                // stall has to be raised in this same cycle so the
                // captured instruction does not retire.
                if (inst_valid_i) begin
                    if (irq_take) begin
                        pc_d      = pc_i;
                        cause_d   = CAUSE_MTI;
                        is_mret_d = 1'b0;
                        state_d   = ST_W_MEPC;
                        stall_o   = 1'b1;
                    end else if (ecall_i) begin
                        pc_d      = pc_i;
                        cause_d   = CAUSE_ECALL;
                        is_mret_d = 1'b0;
                        state_d   = ST_W_MEPC;
                        stall_o   = 1'b1;
                    end else if (mret_i) begin
                        is_mret_d = 1'b1;
                        state_d   = ST_R_MSTATUS;
                        stall_o   = 1'b1;
                    end
                end
            end

            ST_W_MEPC: begin
                stall_o = 1'b1;
                if (!cpu_csr_wen_i) begin
                    clint_csr_wen_o   = 1'b1;
                    clint_csr_waddr_o = ADDR_MEPC;
                    clint_csr_wdata_o = pc_q;
                    state_d           = ST_W_MCAUSE;
                end
            end

            ST_W_MCAUSE: begin
                stall_o = 1'b1;
                if (!cpu_csr_wen_i) begin
                    clint_csr_wen_o   = 1'b1;
                    clint_csr_waddr_o = ADDR_MCAUSE;
                    clint_csr_wdata_o = cause_q;
                    state_d           = ST_W_MSTATUS;
                end
            end

            ST_W_MSTATUS: begin
                // mstatus is sampled now, so earlier CPU writes are kept.
                stall_o = 1'b1;
                if (!cpu_csr_wen_i) begin
                    clint_csr_wen_o   = 1'b1;
                    clint_csr_waddr_o = ADDR_MSTATUS;
                    clint_csr_wdata_o = mstatus_on_trap(csr_mstatus_i);
                    state_d           = ST_JUMP;
                end
            end

            ST_R_MSTATUS: begin
                stall_o = 1'b1;
                if (!cpu_csr_wen_i) begin
                    clint_csr_wen_o   = 1'b1;
                    clint_csr_waddr_o = ADDR_MSTATUS;
                    clint_csr_wdata_o = mstatus_on_mret(csr_mstatus_i);
                    state_d           = ST_JUMP;
                end
            end

            ST_JUMP: begin
                stall_o     = 1'b1;
                trap_jump_o = 1'b1;
                trap_pc_o   = is_mret_q ? csr_mepc_i : trap_target;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // While reset is asserted every output is quiet, even though the
        // state register only clears on the next edge.
        if (!rst_n) begin
            clint_csr_wen_o   = 1'b0;
            clint_csr_waddr_o = 12'h000;
            clint_csr_wdata_o = '0;
            stall_o           = 1'b0;
            trap_jump_o       = 1'b0;
            trap_pc_o         = '0;
        end
    end

endmodule : clint_trap_ctrl

// File: tb/tb_clint_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clint_trap_ctrl
//
// Directed scenarios for the trap sequencer followed by a randomized run.
// Every cycle the outputs are compared against a transaction-level model: a
// trigger queues the list of CSR writes and the final redirect; each cycle
// the head of the list is expected (writes are deferred while the CPU owns
// the CSR port). Directed scenarios additionally check the logged writes and
// redirect timing against fixed values.
// ----------------------------------------------------------------------------
module tb_clint_trap_ctrl;

    localparam logic [63:0] C_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] C_ECALL = 64'd11;

    logic        clk;
    logic        rst_n;
    logic        inst_valid_i;
    logic [63:0] pc_i;
    logic        ecall_i;
    logic        mret_i;
    logic        cpu_csr_wen_i;
    logic [63:0] csr_mtvec_i;
    logic [63:0] csr_mepc_i;
    logic [63:0] csr_mstatus_i;
    logic        global_int_en_i;
    logic        mtime_int_en_i;
    logic        mtime_int_pend_i;
    logic        clint_csr_wen_o;
    logic [11:0] clint_csr_waddr_o;
    logic [63:0] clint_csr_wdata_o;
    logic        stall_o;
    logic        trap_jump_o;
    logic [63:0] trap_pc_o;

    clint_trap_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .inst_valid_i      (inst_valid_i),
        .pc_i              (pc_i),
        .ecall_i           (ecall_i),
        .mret_i            (mret_i),
        .cpu_csr_wen_i     (cpu_csr_wen_i),
        .csr_mtvec_i       (csr_mtvec_i),
        .csr_mepc_i        (csr_mepc_i),
        .csr_mstatus_i     (csr_mstatus_i),
        .global_int_en_i   (global_int_en_i),
        .mtime_int_en_i    (mtime_int_en_i),
        .mtime_int_pend_i  (mtime_int_pend_i),
        .clint_csr_wen_o   (clint_csr_wen_o),
        .clint_csr_waddr_o (clint_csr_waddr_o),
        .clint_csr_wdata_o (clint_csr_wdata_o),
        .stall_o           (stall_o),
        .trap_jump_o       (trap_jump_o),
        .trap_pc_o         (trap_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%h expected=0x%h", tag, cyc, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending work as a list of operations
    // ------------------------------------------------------------------
    localparam int OP_MEPC = 0, OP_MCAUSE = 1, OP_TSTAT = 2, OP_RSTAT = 3,
                   OP_TJUMP = 4, OP_RJUMP = 5;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } op_t;

    op_t ops[$];

    function automatic op_t mk(input int k, input logic [63:0] v);
        op_t o;
        o.kind = k;
        o.val  = v;
        return o;
    endfunction

    function automatic logic [63:0] trap_status(input logic [63:0] s);
        logic [63:0] mie;
        mie = (s >> 3) & 64'd1;
        return (s & ~64'h0000_0000_0000_1888) | (mie << 7) | (64'd3 << 11);
    endfunction

    function automatic logic [63:0] mret_status(input logic [63:0] s);
        logic [63:0] mpie;
        mpie = (s >> 7) & 64'd1;
        return (s & ~64'h0000_0000_0000_1888) | mpie * 64'd8 | 64'h80 | 64'h1800;
    endfunction

    function automatic logic [63:0] trap_dest(input logic [63:0] mtvec, input logic [63:0] cause);
        logic [63:0] base;
        base = mtvec - (mtvec % 64'd4);
`ifdef CLINT_VECTORED_EN
        if ((mtvec % 64'd4) == 64'd1 && cause >= 64'h8000_0000_0000_0000)
            return base + 64'd4 * (cause - 64'h8000_0000_0000_0000);
`endif
        return base;
    endfunction

    // Logs of what the DUT actually did, for directed checks.
    typedef struct {
        int          t;
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;
    wr_t wlog[$];
    int          jcyc[$];
    logic [63:0] jpc[$];

    task automatic model_cycle();
        logic        e_wen, e_stall, e_jump;
        logic [11:0] e_addr;
        logic [63:0] e_data, e_pc;
        logic        irq;
        e_wen = 0; e_stall = 0; e_jump = 0; e_addr = 0; e_data = 0; e_pc = 0;
        irq = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
        if (!rst_n) begin
            ops.delete();
        end else if (ops.size() > 0) begin
            e_stall = 1;
            if (ops[0].kind >= OP_TJUMP) begin
                e_jump = 1;
                e_pc   = (ops[0].kind == OP_RJUMP) ? csr_mepc_i
                                                   : trap_dest(csr_mtvec_i, ops[0].val);
                void'(ops.pop_front());
            end else if (!cpu_csr_wen_i) begin
                e_wen = 1;
                case (ops[0].kind)
                    OP_MEPC:   begin e_addr = 12'h341; e_data = ops[0].val; end
                    OP_MCAUSE: begin e_addr = 12'h342; e_data = ops[0].val; end
                    OP_TSTAT:  begin e_addr = 12'h300; e_data = trap_status(csr_mstatus_i); end
                    default:   begin e_addr = 12'h300; e_data = mret_status(csr_mstatus_i); end
                endcase
                void'(ops.pop_front());
            end
        end else if (inst_valid_i && (irq || ecall_i || mret_i)) begin
            e_stall = 1;
            if (irq || ecall_i) begin
                ops.push_back(mk(OP_MEPC, pc_i));
                ops.push_back(mk(OP_MCAUSE, irq ? C_MTI : C_ECALL));
                ops.push_back(mk(OP_TSTAT, 0));
                ops.push_back(mk(OP_TJUMP, irq ? C_MTI : C_ECALL));
            end else begin
                ops.push_back(mk(OP_RSTAT, 0));
                ops.push_back(mk(OP_RJUMP, 0));
            end
        end
        check("wen",   {63'd0, clint_csr_wen_o}, {63'd0, e_wen});
        check("waddr", {52'd0, clint_csr_waddr_o}, {52'd0, e_addr});
        check("wdata", clint_csr_wdata_o, e_data);
        check("stall", {63'd0, stall_o}, {63'd0, e_stall});
        check("jump",  {63'd0, trap_jump_o}, {63'd0, e_jump});
        check("tpc",   trap_pc_o, e_pc);
    endtask

    task automatic tick();
        @(negedge clk);
        if (clint_csr_wen_o) wlog.push_back('{cyc, clint_csr_waddr_o, clint_csr_wdata_o});
        if (trap_jump_o) begin
            jcyc.push_back(cyc);
            jpc.push_back(trap_pc_o);
        end
        model_cycle();
        $display("cyc=%0d rst_n=%0d iv=%0d ec=%0d mr=%0d irq=%0d cpuw=%0d | wen=%0d addr=%h data=%h stall=%0d jump=%0d pc=%h",
                 cyc, rst_n, inst_valid_i, ecall_i, mret_i,
                 global_int_en_i & mtime_int_en_i & mtime_int_pend_i, cpu_csr_wen_i,
                 clint_csr_wen_o, clint_csr_waddr_o, clint_csr_wdata_o, stall_o,
                 trap_jump_o, trap_pc_o);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_valid_i = 0; ecall_i = 0; mret_i = 0; cpu_csr_wen_i = 0;
        global_int_en_i = 0; mtime_int_en_i = 0; mtime_int_pend_i = 0;
    endtask

    task automatic clear_logs();
        wlog.delete(); jcyc.delete(); jpc.delete();
    endtask

    task automatic check_wr(input string tag, input int idx, input int t,
                            input logic [11:0] a, input logic [63:0] d);
        if (idx >= wlog.size()) begin
            check({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_time"}, 64'(wlog[idx].t), 64'(t));
            check({tag, "_addr"}, {52'd0, wlog[idx].addr}, {52'd0, a});
            check({tag, "_data"}, wlog[idx].data, d);
        end
    endtask

    task automatic check_jump(input string tag, input int t, input logic [63:0] pc);
        if (jcyc.size() != 1) begin
            check({tag, "_count"}, 64'(jcyc.size()), 64'd1);
        end else begin
            check({tag, "_time"}, 64'(jcyc[0]), 64'(t));
            check({tag, "_pc"}, jpc[0], pc);
        end
    endtask

    int t0;

    initial begin
        rst_n = 0;
        pc_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        idle_inputs();
        #1;
        repeat (3) tick();
        rst_n = 1;
        tick();

        // 1: timer interrupt
        clear_logs();
        csr_mstatus_i = 64'h8; csr_mtvec_i = 64'h8000_0100;
        global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
        inst_valid_i = 1; pc_i = 64'h8000_0010;
        t0 = cyc;
        tick();
        idle_inputs();
        repeat (5) tick();
        check("t1_nwr", 64'(wlog.size()), 64'd3);
        check_wr("t1_mepc",   0, t0 + 1, 12'h341, 64'h8000_0010);
        check_wr("t1_mcause", 1, t0 + 2, 12'h342, C_MTI);
        check_wr("t1_mstat",  2, t0 + 3, 12'h300, 64'h1880);
        check_jump("t1_jump", t0 + 4, 64'h8000_0100);

        // 2: ECALL
        clear_logs();
        csr_mtvec_i = 64'h8000_0203;
        inst_valid_i = 1; ecall_i = 1; pc_i = 64'h8000_0020;
        t0 = cyc;
        tick();
        idle_inputs();
        repeat (5) tick();
        check_wr("t2_mepc",   0, t0 + 1, 12'h341, 64'h8000_0020);
        check_wr("t2_mcause", 1, t0 + 2, 12'h342, 64'd11);
        check_jump("t2_jump", t0 + 4, 64'h8000_0200);

        // 3: MRET
        clear_logs();
        csr_mstatus_i = 64'h80; csr_mepc_i = 64'h8000_0024;
        inst_valid_i = 1; mret_i = 1;
        t0 = cyc;
        tick();
        idle_inputs();
        repeat (3) tick();
        check_wr("t3_mstat", 0, t0 + 1, 12'h300, 64'h1888);
        check_jump("t3_jump", t0 + 2, 64'h8000_0024);

        // 4: CPU owns the CSR port for two cycles during mcause
        clear_logs();
        csr_mtvec_i = 64'h8000_0100;
        inst_valid_i = 1; ecall_i = 1; pc_i = 64'h8000_0030;
        t0 = cyc;
        tick();
        idle_inputs();
        tick();
        cpu_csr_wen_i = 1;
        repeat (2) tick();
        cpu_csr_wen_i = 0;
        repeat (4) tick();
        check_wr("t4_mcause", 1, t0 + 4, 12'h342, 64'd11);
        check_jump("t4_jump", t0 + 6, 64'h8000_0100);

        // 5: interrupt beats ecall; masked interrupt does nothing
        clear_logs();
        inst_valid_i = 1; ecall_i = 1; pc_i = 64'h8000_0040;
        global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
        tick();
        idle_inputs();
        repeat (5) tick();
        check_wr("t5_mcause", 1, wlog.size() > 1 ? wlog[1].t : 0, 12'h342, C_MTI);
        clear_logs();
        inst_valid_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        check("t5_masked_nwr", 64'(wlog.size()), 64'd0);

        // 6: reset during mcause aborts the sequence
        clear_logs();
        inst_valid_i = 1; ecall_i = 1; pc_i = 64'h8000_0050;
        tick();
        idle_inputs();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        repeat (4) tick();
        check("t6_nwr", 64'(wlog.size()), 64'd1);
        check("t6_njump", 64'(jcyc.size()), 64'd0);

`ifdef CLINT_VECTORED_EN
        clear_logs();
        csr_mtvec_i = 64'h8000_0101;
        inst_valid_i = 1; pc_i = 64'h8000_0060;
        global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
        t0 = cyc;
        tick();
        idle_inputs();
        repeat (5) tick();
        check_jump("t6v_jump", t0 + 4, 64'h8000_011C);
`endif

        // Randomized run, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            rst_n            = ($urandom_range(0, 199) != 0);
            inst_valid_i     = ($urandom_range(0, 2) != 0);
            pc_i             = {$urandom, $urandom};
            ecall_i          = ($urandom_range(0, 5) == 0);
            mret_i           = ($urandom_range(0, 5) == 0);
            cpu_csr_wen_i    = ($urandom_range(0, 3) == 0);
            global_int_en_i  = $urandom_range(0, 1) == 1;
            mtime_int_en_i   = $urandom_range(0, 1) == 1;
            mtime_int_pend_i = ($urandom_range(0, 3) == 0);
            csr_mstatus_i    = {$urandom, $urandom};
            csr_mepc_i       = {$urandom, $urandom};
            csr_mtvec_i      = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) csr_mtvec_i[1:0] = 2'b01;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clint_trap_ctrl
